// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, functs, FSM states,
// ALU operations and the small ALU helpers used by the core.
package mips_mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

    function automatic logic r_funct_legal(input logic [5:0] funct);
        return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

    function automatic alu_op_e alu_op_of(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [31:0] alu_eval(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
            default: return a + b;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_if.sv
// Shared instruction/data memory port with a single-cycle ready handshake.
interface mips_mc_if #(
    parameter int MEM_ADDR_W = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ready);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ready);
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// $0 reads as zero and ignores writes.
module mips_regfile (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i
);
    logic [31:0] regs_q [32];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];
endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS-32 core on a single shared memory port with ready handshake.
// Optional feature: define MIPS_MC_BNE_EN to make bne a legal branch.
module mips_mc_core
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_ADDR_W = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    mips_mc_if.master   mem,
    output logic        halted,
    output logic [31:0] pc_out
);
    state_e      state_q;
    logic [31:0] pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
    logic        halted_q;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, rs_data, rt_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] addr_full;
    logic        req, we, branch_taken;
    state_e      decode_next;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    mips_regfile u_rf (
        .clk_i (CLK),
        .rst_i (RESET),
        .ra1_i (rs),
        .ra2_i (rt),
        .rd1_o (rs_data),
        .rd2_o (rt_data),
        .we_i  (rf_we),
        .wa_i  (rf_waddr),
        .wd_i  (rf_wdata)
    );

    always_comb begin
        decode_next = S_HALT;
        case (opcode)
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_RTYPE:     decode_next = r_funct_legal(funct) ? S_EXEC : S_HALT;
            OP_BEQ:       decode_next = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
            OP_BNE:       decode_next = S_BRANCH;
`endif
            OP_ADDI:      decode_next = S_ADDIEX;
            OP_J:         decode_next = S_JUMP;
            default:      decode_next = S_HALT;
        endcase
    end

`ifdef MIPS_MC_BNE_EN
    assign branch_taken = (opcode == OP_BNE) ? (a_q != b_q) : (a_q == b_q);
`else
    assign branch_taken = (a_q == b_q);
`endif

    // The bus is quiet while RESET is held even though the state already reads FETCH.
    always_comb begin
        req       = 1'b0;
        we        = 1'b0;
        addr_full = pc_q;
        if (!RESET) begin
            case (state_q)
                S_FETCH: req = 1'b1;
                S_MEMRD: begin req = 1'b1; addr_full = aluout_q; end
                S_MEMWR: begin req = 1'b1; we = 1'b1; addr_full = aluout_q; end
                default: ;
            endcase
        end
    end

    assign mem.mem_req   = req;
    assign mem.mem_we    = we;
    assign mem.mem_addr  = {addr_full[MEM_ADDR_W-1:2], 2'b00};
    assign mem.mem_wdata = b_q;

    assign rf_we    = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_ADDIWB);
    assign rf_waddr = (state_q == S_ALUWB) ? rd : rt;
    assign rf_wdata = (state_q == S_MEMWB) ? mdr_q : aluout_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: if (mem.mem_ready) begin
                    ir_q    <= mem.mem_rdata;
                    pc_q    <= pc_q + 32'd4;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    a_q      <= rs_data;
                    b_q      <= rt_data;
                    aluout_q <= pc_q + {imm_sext[29:0], 2'b00};
                    state_q  <= decode_next;
                    if (decode_next == S_HALT) halted_q <= 1'b1;
                end
                S_MEMADR: begin
                    aluout_q <= a_q + imm_sext;
                    state_q  <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: if (mem.mem_ready) begin
                    mdr_q   <= mem.mem_rdata;
                    state_q <= S_MEMWB;
                end
                S_MEMWR: if (mem.mem_ready) state_q <= S_FETCH;
                S_EXEC: begin
                    aluout_q <= alu_eval(alu_op_of(funct), a_q, b_q);
                    state_q  <= S_ALUWB;
                end
                S_ADDIEX: begin
                    aluout_q <= a_q + imm_sext;
                    state_q  <= S_ADDIWB;
                end
                S_BRANCH: begin
                    if (branch_taken) pc_q <= aluout_q;
                    state_q <= S_FETCH;
                end
                S_JUMP: begin
                    pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
                    state_q <= S_FETCH;
                end
                S_MEMWB, S_ALUWB, S_ADDIWB: state_q <= S_FETCH;
                S_HALT: ;
                default: begin
                    state_q  <= S_HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign halted = halted_q;
    assign pc_out = pc_q;
endmodule

// File: tb/tb_mips_mc_core.sv
// Bench for mips_mc_core: an instruction-level model predicts every bus cycle,
// pc_out and halted; directed programs add hand-computed literal expectations.
module tb_mips_mc_core;
    localparam int MAXC = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_mc_if #(.MEM_ADDR_W(32)) bus0 ();
    mips_mc_if #(.MEM_ADDR_W(32)) bus1 ();
    logic h0, h1;
    logic [31:0] p0, p1;

    mips_mc_core #(.RESET_PC(32'h0000_0000), .MEM_ADDR_W(32)) dut0 (
        .CLK(clk), .RESET(rst), .mem(bus0), .halted(h0), .pc_out(p0));
    mips_mc_core #(.RESET_PC(32'h0000_0100), .MEM_ADDR_W(32)) dut1 (
        .CLK(clk), .RESET(rst), .mem(bus1), .halted(h1), .pc_out(p1));

    int sel = 0;
    int wait_n = 0;
    logic rdy = 1'b0;
    logic [31:0] rdata_v = '0;
    assign bus0.mem_ready = (sel == 0) && rdy;
    assign bus1.mem_ready = (sel == 1) && rdy;
    assign bus0.mem_rdata = rdata_v;
    assign bus1.mem_rdata = rdata_v;

    logic q_req, q_we, q_halt;
    logic [31:0] q_addr, q_wdata, q_pc;
    always_comb begin
        if (sel == 1) begin
            q_req = bus1.mem_req; q_we = bus1.mem_we; q_addr = bus1.mem_addr;
            q_wdata = bus1.mem_wdata; q_halt = h1; q_pc = p1;
        end else begin
            q_req = bus0.mem_req; q_we = bus0.mem_we; q_addr = bus0.mem_addr;
            q_wdata = bus0.mem_wdata; q_halt = h0; q_pc = p0;
        end
    end

    logic [31:0] mem [256];
    logic [31:0] mm  [256];
    logic [31:0] mr  [32];
    logic        e_req [MAXC], e_we [MAXC], e_halt [MAXC];
    logic [31:0] e_addr [MAXC], e_wd [MAXC], e_pc [MAXC];
    logic        a_req [MAXC], a_halt [MAXC];
    logic [31:0] a_addr [MAXC], a_pc [MAXC];
    int mc;
    logic [31:0] mpc;
    logic mhalt;
    int w_cyc, w_start;
    logic [31:0] w_addr, w_data;
    int checks = 0;
    int errors = 0;
    int cur_cyc = 0;
    string tname = "";

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s cyc=%0d actual=%h expected=%h", tname, nm, cur_cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ei(input int op, input int rs, input int rt, input int imm);
        logic [31:0] o, s, t, i;
        o = op; s = rs; t = rt; i = imm;
        return {o[5:0], s[4:0], t[4:0], i[15:0]};
    endfunction

    function automatic logic [31:0] er(input int rs, input int rt, input int rd, input int fn);
        logic [31:0] s, t, d, f;
        s = rs; t = rt; d = rd; f = fn;
        return {6'h00, s[4:0], t[4:0], d[4:0], 5'h00, f[5:0]};
    endfunction

    task automatic mark(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd);
        if (mc < MAXC) begin
            e_req[mc] = req; e_we[mc] = we; e_addr[mc] = addr; e_wd[mc] = wd;
            e_pc[mc] = mpc; e_halt[mc] = mhalt;
        end
        mc++;
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        for (int k = 0; k <= wait_n; k++) mark(1'b1, we, addr, wd);
    endtask

    task automatic setr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) mr[r] = v;
    endtask

    // Instruction-level model: each instruction expands into its bus/idle cycles.
    task automatic build(input logic [31:0] rpc, input int ncyc);
        mm = mem;
        for (int i = 0; i < 32; i++) mr[i] = '0;
        mpc = rpc; mhalt = 1'b0; mc = 1;
        while (mc <= ncyc && !mhalt) begin
            logic [31:0] ir, simm, ea, res;
            logic [5:0] op, fn;
            logic [4:0] rs, rt, rd;
            logic bad;
            access(1'b0, mpc, '0);
            ir = mm[mpc[9:2]];
            mpc = mpc + 32'd4;
            mark(1'b0, 1'b0, '0, '0);
            op = ir[31:26]; fn = ir[5:0]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
            simm = {{16{ir[15]}}, ir[15:0]};
            bad = 1'b0;
            res = '0;
            case (op)
                6'h23: begin
                    mark(1'b0, 1'b0, '0, '0);
                    ea = mr[rs] + simm;
                    access(1'b0, ea, '0);
                    mark(1'b0, 1'b0, '0, '0);
                    setr(rt, mm[ea[9:2]]);
                end
                6'h2B: begin
                    mark(1'b0, 1'b0, '0, '0);
                    ea = mr[rs] + simm;
                    access(1'b1, ea, mr[rt]);
                    mm[ea[9:2]] = mr[rt];
                end
                6'h00: begin
                    case (fn)
                        6'h20: res = mr[rs] + mr[rt];
                        6'h22: res = mr[rs] - mr[rt];
                        6'h24: res = mr[rs] & mr[rt];
                        6'h25: res = mr[rs] | mr[rt];
                        6'h2A: res = ($signed(mr[rs]) < $signed(mr[rt])) ? 32'd1 : 32'd0;
                        default: bad = 1'b1;
                    endcase
                    if (!bad) begin
                        mark(1'b0, 1'b0, '0, '0); mark(1'b0, 1'b0, '0, '0);
                        setr(rd, res);
                    end
                end
                6'h08: begin
                    mark(1'b0, 1'b0, '0, '0); mark(1'b0, 1'b0, '0, '0);
                    setr(rt, mr[rs] + simm);
                end
                6'h04: begin
                    mark(1'b0, 1'b0, '0, '0);
                    if (mr[rs] == mr[rt]) mpc = mpc + (simm << 2);
                end
                6'h05: begin
`ifdef MIPS_MC_BNE_EN
                    mark(1'b0, 1'b0, '0, '0);
                    if (mr[rs] != mr[rt]) mpc = mpc + (simm << 2);
`else
                    bad = 1'b1;
`endif
                end
                6'h02: begin
                    mark(1'b0, 1'b0, '0, '0);
                    mpc = {mpc[31:28], ir[25:0], 2'b00};
                end
                default: bad = 1'b1;
            endcase
            if (bad) mhalt = 1'b1;
        end
        while (mc <= ncyc) mark(1'b0, 1'b0, '0, '0);
    endtask

    task automatic clr_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    // Entered at a negedge: reset for two edges, release, then compare every cycle.
    task automatic run(input string nm, input int s, input int w, input logic [31:0] rpc,
                       input int ncyc);
        int wcnt;
        tname = nm; sel = s; wait_n = w;
        build(rpc, ncyc);
        rst = 1'b1; rdy = 1'b0; wcnt = 0;
        w_cyc = 0; w_start = 0; w_addr = '0; w_data = '0;
        cur_cyc = 0;
        for (int r = 0; r < 2; r++) begin
            #1;
            check("rst_req", {31'b0, q_req}, 32'd0);
            check("rst_we", {31'b0, q_we}, 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            #1;
            cur_cyc = c;
            a_req[c] = q_req; a_addr[c] = q_addr; a_halt[c] = q_halt; a_pc[c] = q_pc;
            check("req", {31'b0, q_req}, {31'b0, e_req[c]});
            check("halted", {31'b0, q_halt}, {31'b0, e_halt[c]});
            check("pc_out", q_pc, e_pc[c]);
            if (e_req[c]) begin
                check("we", {31'b0, q_we}, {31'b0, e_we[c]});
                check("addr", q_addr, e_addr[c]);
                if (e_we[c]) check("wdata", q_wdata, e_wd[c]);
            end
            if (q_req) begin
                if (q_we && w_start == 0) w_start = c;
                if (wcnt >= wait_n) begin
                    rdy = 1'b1;
                    rdata_v = mem[q_addr[9:2]];
                    if (q_we) begin
                        mem[q_addr[9:2]] = q_wdata;
                        if (w_cyc == 0) begin w_cyc = c; w_addr = q_addr; w_data = q_wdata; end
                    end
                    wcnt = 0;
                end else begin
                    rdy = 1'b0;
                    rdata_v = 32'hDEAD_BEEF;
                    wcnt++;
                end
            end else begin
                rdy = 1'b1;
                rdata_v = 32'hBAD0_BAD0;
                wcnt = 0;
            end
            @(negedge clk);
        end
        cur_cyc = 0;
    endtask

    task automatic load_basic();
        clr_mem();
        mem[0] = ei(8, 0, 1, 5);
        mem[1] = ei(8, 0, 2, 7);
        mem[2] = er(1, 2, 3, 32);
        mem[3] = ei(43, 0, 3, 32'h40);
    endtask

    initial begin
        @(negedge clk);

        // Pin instruction encodings used below.
        check("enc_addi", ei(8, 0, 1, 5), 32'h2001_0005);
        check("enc_add", er(1, 2, 3, 32), 32'h0022_1820);
        check("enc_sw", ei(43, 0, 3, 32'h40), 32'hAC03_0040);

        load_basic();
        run("zero_wait", 0, 0, 32'h0, 24);
        check("first_req", {31'b0, a_req[1]}, 32'd1);
        check("first_addr", a_addr[1], 32'h0);
        check("sw_cycle", w_cyc, 16);
        check("sw_addr", w_addr, 32'h40);
        check("sw_data", w_data, 32'd12);
        check("halt_before", {31'b0, a_halt[18]}, 32'd0);
        check("halt_rise", {31'b0, a_halt[19]}, 32'd1);
        check("halt_pc", a_pc[19], 32'h14);

        load_basic();
        run("wait2", 0, 2, 32'h0, 40);
        check("sw_start", w_start, 24);
        check("sw_cycle", w_cyc, 26);
        check("sw_data", w_data, 32'd12);
        check("halt_rise", {31'b0, a_halt[31]}, 32'd1);

        clr_mem();
        mem[0] = ei(8, 0, 1, 3);
        mem[1] = ei(8, 0, 2, 4);
        mem[2] = ei(4, 1, 1, 2);
        mem[3] = ei(8, 0, 4, 1);
        run("beq_taken", 0, 0, 32'h0, 14);
        check("next_fetch", a_addr[12], 32'h14);
        mem[2] = ei(4, 1, 2, 2);
        run("beq_not", 0, 0, 32'h0, 14);
        check("next_fetch", a_addr[12], 32'h0C);

        clr_mem();
        mem[64] = ei(2, 0, 0, 32'h40);
        run("reset_pc", 1, 0, 32'h100, 10);
        check("first_addr", a_addr[1], 32'h100);
        check("j_fetch_req", {31'b0, a_req[4]}, 32'd1);
        check("j_fetch_addr", a_addr[4], 32'h100);

        clr_mem();
        mem[0] = ei(8, 0, 1, 1);
        mem[1] = ei(5, 1, 0, 1);
        mem[3] = ei(43, 0, 1, 32'h40);
        run("bne", 0, 0, 32'h0, 20);
`ifdef MIPS_MC_BNE_EN
        check("bne_fetch", a_addr[8], 32'h0C);
`else
        check("bne_halt", {31'b0, a_halt[7]}, 32'd1);
        check("bne_pc", a_pc[7], 32'h08);
        check("bne_quiet", {31'b0, a_req[15]}, 32'd0);
`endif

        clr_mem();
        mem[0]  = ei(35, 0, 5, 32'h40);
        mem[16] = 32'h1234_5678;
        run("lw_abort", 0, 3, 32'h0, 8);
        check("memrd_req", {31'b0, a_req[8]}, 32'd1);
        check("memrd_addr", a_addr[8], 32'h40);
        mem[0] = ei(43, 0, 5, 32'h44);
        run("after_rst", 0, 0, 32'h0, 12);
        check("restart_addr", a_addr[1], 32'h0);
        check("sw_cycle", w_cyc, 4);
        check("rt_unchanged", w_data, 32'd0);

        clr_mem();
        mem[0]  = ei(8, 0, 1, -3);
        mem[1]  = ei(8, 0, 2, 5);
        mem[2]  = er(1, 2, 3, 34);
        mem[3]  = er(1, 2, 4, 36);
        mem[4]  = er(1, 2, 5, 37);
        mem[5]  = er(1, 2, 6, 42);
        mem[6]  = er(2, 1, 7, 42);
        mem[7]  = ei(8, 0, 0, 9);
        mem[8]  = ei(43, 0, 3, 32'h80);
        mem[9]  = ei(43, 0, 6, 32'h84);
        mem[10] = ei(35, 0, 8, 32'h80);
        mem[11] = ei(43, 0, 8, 32'h88);
        mem[12] = ei(43, 0, 0, 32'h8C);
        mem[13] = ei(43, 0, 4, 32'h90);
        mem[14] = ei(43, 0, 5, 32'h94);
        mem[15] = ei(43, 0, 7, 32'h98);
        mem[38] = 32'hFFFF_FFFF;
        run("alu_mix", 0, 1, 32'h0, 110);
        check("sub", mem[32], 32'hFFFF_FFF8);
        check("slt_true", mem[33], 32'd1);
        check("lw_back", mem[34], 32'hFFFF_FFF8);
        check("zero_reg", mem[35], 32'd0);
        check("and", mem[36], 32'd5);
        check("or", mem[37], 32'hFFFF_FFFD);
        check("slt_false", mem[38], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
